corevx_ptw: RTL

Sv32 hardware page-table walker for the corevx cache/MMU path.
- On a TLB miss the cache controller hands it a virtual page number.
- It reads up to two PTEs over the cache backing-memory read port and returns the leaf PPN plus the 8-bit access tag (D A G U X W R V), or a fault.
- The returned access tag is written into the TLB and later checked by the permission/pagefault logic; this block only reports structural walk faults.

---
 rtl/corevx_ptw_pkg.sv | 34 +++
 rtl/corevx_ptw.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/corevx_ptw_pkg.sv
// Shared definitions for the corevx Sv32 page-table walker: walk states,
// PTE access-tag bit positions and memory response codes.
package corevx_ptw_pkg;

   localparam int PADDR_W  = 34;
   localparam int PPN_W    = 22;
   localparam int VPN_W    = 20;
   localparam int VPN_SEG_W = 10;

   localparam int ACCESSTAG_V_BIT_NUM = 0;
   localparam int ACCESSTAG_R_BIT_NUM = 1;
   localparam int ACCESSTAG_W_BIT_NUM = 2;
   localparam int ACCESSTAG_X_BIT_NUM = 3;
   localparam int ACCESSTAG_U_BIT_NUM = 4;
   localparam int ACCESSTAG_G_BIT_NUM = 5;
   localparam int ACCESSTAG_A_BIT_NUM = 6;
   localparam int ACCESSTAG_D_BIT_NUM = 7;

   localparam logic [1:0] MEM_RESPONSE_OKAY = 2'b00;

   typedef enum logic [1:0] {
      PTW_IDLE  = 2'd0,
      PTW_ISSUE = 2'd1,
      PTW_WAIT  = 2'd2,
      PTW_DONE  = 2'd3
   } ptw_state_e;

   // PTE byte address of entry 'idx' in the table at page 'ppn'.
   function automatic logic [PADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] ppn,
                                                   input logic [VPN_SEG_W-1:0] idx);
      return {ppn, idx, 2'b00};
   endfunction

endpackage

// File: rtl/corevx_ptw.sv
// Sv32 hardware page-table walker: up to two PTE reads over the backing-memory
// read port, returning the leaf PPN and access tag or a structural fault.
//
//  state | meaning
//  IDLE  | waiting for resolve_request; acks and captures VA/satp
//  ISSUE | mem_read asserted, address held until !mem_waitrequest
//  WAIT  | address accepted, waiting for mem_readdatavalid, PTE evaluated
//  DONE  | one-cycle resolve_done with registered result
module corevx_ptw
   import corevx_ptw_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 resolve_request,
   input  logic [VPN_W-1:0]     resolve_virtual_address,
   input  logic [PPN_W-1:0]     satp_ppn,
   output logic                 resolve_ack,
   output logic                 resolve_done,
   output logic                 resolve_pagefault,
   output logic                 resolve_accessfault,
   output logic [PPN_W-1:0]     resolve_physical_address,
   output logic [7:0]           resolve_access_bits,
   output logic                 mem_read,
   output logic [PADDR_W-1:0]   mem_address,
   input  logic                 mem_waitrequest,
   input  logic                 mem_readdatavalid,
   input  logic [31:0]          mem_readdata,
   input  logic [1:0]           mem_response
);

   ptw_state_e               state_q, state_d;
   logic                     level_q, level_d;
   logic [VPN_SEG_W-1:0]     vpn0_q, vpn0_d;
   logic [PADDR_W-1:0]       addr_q, addr_d;
   logic                     pf_q, pf_d;
   logic                     af_q, af_d;
   logic [PPN_W-1:0]         ppn_q, ppn_d;
   logic [7:0]               bits_q, bits_d;

   logic                     pte_v, pte_r, pte_w, pte_x;
   logic                     pte_invalid, pte_leaf, pte_misaligned, pte_ptr_rsvd;
   logic [PPN_W-1:0]         pte_ppn;
   logic                     unused_rsw;

   assign pte_v   = mem_readdata[ACCESSTAG_V_BIT_NUM];
   assign pte_r   = mem_readdata[ACCESSTAG_R_BIT_NUM];
   assign pte_w   = mem_readdata[ACCESSTAG_W_BIT_NUM];
   assign pte_x   = mem_readdata[ACCESSTAG_X_BIT_NUM];
   assign pte_ppn = mem_readdata[31:10];

   assign pte_invalid    = !pte_v || (!pte_r && pte_w);
   assign pte_leaf       = pte_r || pte_x;
   assign pte_misaligned = |mem_readdata[19:10];
   assign pte_ptr_rsvd   = mem_readdata[ACCESSTAG_D_BIT_NUM]
                         | mem_readdata[ACCESSTAG_A_BIT_NUM]
                         | mem_readdata[ACCESSTAG_U_BIT_NUM];

   // RSW bits are software-owned and play no part in the walk.
   assign unused_rsw = ^mem_readdata[9:8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PTW_IDLE;
         level_q <= 1'b0;
         vpn0_q  <= '0;
         addr_q  <= '0;
         pf_q    <= 1'b0;
         af_q    <= 1'b0;
         ppn_q   <= '0;
         bits_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         vpn0_q  <= vpn0_d;
         addr_q  <= addr_d;
         pf_q    <= pf_d;
         af_q    <= af_d;
         ppn_q   <= ppn_d;
         bits_q  <= bits_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      vpn0_d      = vpn0_q;
      addr_d      = addr_q;
      pf_d        = pf_q;
      af_d        = af_q;
      ppn_d       = ppn_q;
      bits_d      = bits_q;
      resolve_ack = 1'b0;

      unique case (state_q)
         PTW_IDLE: begin
            if (resolve_request) begin
               resolve_ack = 1'b1;
               vpn0_d      = resolve_virtual_address[9:0];
               level_d     = 1'b1;
               addr_d      = pte_addr(satp_ppn, resolve_virtual_address[19:10]);
               pf_d        = 1'b0;
               af_d        = 1'b0;
               ppn_d       = '0;
               bits_d      = '0;
               state_d     = PTW_ISSUE;
            end
         end
         PTW_ISSUE: begin
            if (!mem_waitrequest) state_d = PTW_WAIT;
         end
         PTW_WAIT: begin
            if (mem_readdatavalid) begin
               state_d = PTW_DONE;
               if (mem_response != MEM_RESPONSE_OKAY) begin
                  af_d = 1'b1;
               end else if (pte_invalid) begin
                  pf_d = 1'b1;
               end else if (pte_leaf) begin
                  if (level_q && pte_misaligned) begin
                     pf_d = 1'b1;
                  end else begin
                     ppn_d  = level_q ? {mem_readdata[31:20], vpn0_q} : pte_ppn;
                     bits_d = mem_readdata[7:0];
                  end
               end else if (!level_q || pte_ptr_rsvd) begin
                  pf_d = 1'b1;
               end else begin
                  level_d = 1'b0;
                  addr_d  = pte_addr(pte_ppn, vpn0_q);
                  state_d = PTW_ISSUE;
               end
            end
         end
         PTW_DONE: begin
            state_d = PTW_IDLE;
         end
         default: begin
            state_d = PTW_IDLE;
         end
      endcase
   end

   assign resolve_done             = (state_q == PTW_DONE);
   assign resolve_pagefault        = resolve_done & pf_q;
   assign resolve_accessfault      = resolve_done & af_q;
   assign resolve_physical_address = resolve_done ? ppn_q : '0;
   assign resolve_access_bits      = resolve_done ? bits_q : '0;
   assign mem_read                 = (state_q == PTW_ISSUE);
   assign mem_address              = addr_q;

endmodule
